// File: rtl/buyruk_sirala_if.sv
// Executor-side handshake between the issue stage and the buyruk execution unit.
//   basla  : 1-cycle issue strobe (issue stage -> executor)
//   buyruk : 9-bit instruction, held stable until the next issue
//   sonuc  : 4-bit result (executor -> issue stage)
//   bitti  : result present (executor -> issue stage)
// The master modport is the issue stage and the slave modport is the executor.
interface buyruk_sirala_if;
  logic       basla;
  logic [8:0] buyruk;
  logic [3:0] sonuc;
  logic       bitti;

  modport master (output basla, output buyruk, input sonuc, input bitti);
  modport slave  (input basla, input buyruk, output sonuc, output bitti);
endinterface

// File: rtl/buyruk_sirala.sv
// buyruk_sirala: issue stage for the 9-bit buyruk execution unit.
// Instructions are buffered in a FIFO and issued one at a time with a one-cycle
// basla pulse. Each 4-bit result is captured when the executor reports bitti, and
// the stage keeps a running count of completed instructions.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   yaz           push yaz_buyruk into the FIFO this cycle
//   yaz_buyruk    9-bit instruction to push
//   calistir      level; 1 allows issuing from the FIFO
//   dolu, bos     FIFO full / empty
//   tasma         sticky, set when a push is attempted while full
//   yurutucu      executor handshake (basla, buyruk, sonuc, bitti)
//   sonuc_cikis   last captured result
//   sonuc_gecerli 1-cycle strobe, sonuc_cikis was updated
//   sayac         completed instruction count, wraps at 255
//   hata          sticky, set on a timeout while waiting for bitti
//   mesgul        FSM is not IDLE
module buyruk_sirala #(
  parameter int DERINLIK    = 8,
  parameter int ZAMAN_ASIMI = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   yaz,
  input  logic [8:0]             yaz_buyruk,
  input  logic                   calistir,
  output logic                   dolu,
  output logic                   bos,
  output logic                   tasma,
  buyruk_sirala_if.master        yurutucu,
  output logic [3:0]             sonuc_cikis,
  output logic                   sonuc_gecerli,
  output logic [7:0]             sayac,
  output logic                   hata,
  output logic                   mesgul
);

  localparam int AW = $clog2(DERINLIK);
  localparam int CW = AW + 1;
  localparam int ZW = $clog2(ZAMAN_ASIMI + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} durum_t;

  durum_t         durum;
  logic [8:0]     bellek [DERINLIK];
  logic [AW-1:0]  yaz_ptr;
  logic [AW-1:0]  oku_ptr;
  logic [CW-1:0]  count;
  logic [ZW-1:0]  zaman;
  logic           push;
  logic           pop;
  logic           issue_ok;

  assign dolu     = (count == CW'(DERINLIK));
  assign bos      = (count == '0);
  assign mesgul   = (durum != IDLE);
  assign push     = yaz && !dolu;
  assign issue_ok = calistir && !bos;
  // A pop happens exactly on the edges where the FSM moves into ISSUE.
  assign pop      = issue_ok && ((durum == IDLE) || (durum == WAIT && yurutucu.bitti));

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      bellek[yaz_ptr] <= yaz_buyruk;
    end
  end

  // Pointers and occupancy. A push while full is rejected even if a pop happens
  // on the same edge, since dolu is derived from the pre-edge count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      count   <= '0;
      tasma   <= 1'b0;
    end else begin
      if (push) yaz_ptr <= yaz_ptr + AW'(1);
      if (pop)  oku_ptr <= oku_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (yaz && dolu) tasma <= 1'b1;
    end
  end

  // Issue FSM with registered executor strobe, result capture and timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum           <= IDLE;
      yurutucu.basla  <= 1'b0;
      yurutucu.buyruk <= '0;
      sonuc_cikis     <= '0;
      sonuc_gecerli   <= 1'b0;
      sayac           <= '0;
      hata            <= 1'b0;
      zaman           <= '0;
    end else begin
      sonuc_gecerli <= 1'b0;
      case (durum)
        IDLE: begin
          if (issue_ok) begin
            durum           <= ISSUE;
            yurutucu.basla  <= 1'b1;
            yurutucu.buyruk <= bellek[oku_ptr];
          end
        end
        ISSUE: begin
          durum          <= WAIT;
          yurutucu.basla <= 1'b0;
          zaman          <= '0;
        end
        WAIT: begin
          if (yurutucu.bitti) begin
            sonuc_cikis   <= yurutucu.sonuc;
            sonuc_gecerli <= 1'b1;
            sayac         <= sayac + 8'd1;
            if (issue_ok) begin
              durum           <= ISSUE;
              yurutucu.basla  <= 1'b1;
              yurutucu.buyruk <= bellek[oku_ptr];
            end else begin
              durum <= IDLE;
            end
          end else if (zaman == ZW'(ZAMAN_ASIMI - 1)) begin
            // This is the ZAMAN_ASIMI-th WAIT cycle without bitti.
            hata  <= 1'b1;
            durum <= IDLE;
          end else begin
            zaman <= zaman + ZW'(1);
          end
        end
        default: durum <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buyruk_sirala.sv
// Self-checking bench for buyruk_sirala (DERINLIK=8, ZAMAN_ASIMI=4).
// A small executor model answers each basla on the following edge with
// bitti=1 and a result computed from the opcode: 0 add, 1 sub, 3 or, else and.
module tb_buyruk_sirala;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       yaz = 1'b0;
  logic [8:0] yaz_buyruk = '0;
  logic       calistir = 1'b0;
  logic       dolu, bos, tasma;
  logic [3:0] sonuc_cikis;
  logic       sonuc_gecerli;
  logic [7:0] sayac;
  logic       hata, mesgul;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         exp_sayac = 0;
  logic       stall = 1'b0;
  logic [3:0] res_q[$];
  int         cyc_q[$];

  buyruk_sirala_if ifc ();

  buyruk_sirala #(.DERINLIK(8), .ZAMAN_ASIMI(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .yaz           (yaz),
    .yaz_buyruk    (yaz_buyruk),
    .calistir      (calistir),
    .dolu          (dolu),
    .bos           (bos),
    .tasma         (tasma),
    .yurutucu      (ifc),
    .sonuc_cikis   (sonuc_cikis),
    .sonuc_gecerli (sonuc_gecerli),
    .sayac         (sayac),
    .hata          (hata),
    .mesgul        (mesgul)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] calc(input logic [8:0] w);
    logic [3:0] a, b;
    a = {1'b0, w[5:3]};
    b = {1'b0, w[2:0]};
    case (w[8:6])
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd3:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Add-opcode word whose result equals k (k = 0..14).
  function automatic logic [8:0] mk(input int k);
    int a;
    a = (k > 7) ? 7 : k;
    return {3'b000, 3'(a), 3'(k - a)};
  endfunction

  // Executor model: result is presented on the edge that ends the basla cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ifc.bitti <= 1'b0;
      ifc.sonuc <= 4'd0;
    end else if (ifc.basla && !stall) begin
      ifc.bitti <= 1'b1;
      ifc.sonuc <= calc(ifc.buyruk);
    end else begin
      ifc.bitti <= 1'b0;
    end
  end

  // Result monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sonuc_gecerli) begin
      res_q.push_back(sonuc_cikis);
      cyc_q.push_back(cyc);
    end
  end

  task automatic push_word(input logic [8:0] w);
    yaz = 1'b1;
    yaz_buyruk = w;
    @(negedge clk);
    yaz = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (res_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [27:0] obs;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs = {ifc.basla, ifc.buyruk, sonuc_cikis, sonuc_gecerli, sayac, tasma, hata, mesgul, dolu, bos};
    if (obs !== 28'd1) begin
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 28'd1);
      n_fail++;
    end
    n_checks++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    res_q.delete();
    cyc_q.delete();
    yaz = 1'b1;
    yaz_buyruk = 9'b000_011_010;
    calistir = 1'b1;
    @(negedge clk);
    yaz = 1'b0;
    @(negedge clk);
    if (ifc.basla !== 1'b1 || ifc.buyruk !== 9'h01A) begin
      $display("[TB] FAIL single_issue: got basla=%b buyruk=%h expected basla=1 buyruk=01a", ifc.basla, ifc.buyruk);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    if (ifc.basla !== 1'b0 || sonuc_gecerli !== 1'b0) begin
      $display("[TB] FAIL single_wait: got basla=%b gecerli=%b expected 0 0", ifc.basla, sonuc_gecerli);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    exp_sayac = 1;
    if (sonuc_gecerli !== 1'b1 || sonuc_cikis !== 4'b0101 || sayac !== 8'(exp_sayac)) begin
      $display("[TB] FAIL single_result: got gecerli=%b sonuc=%h sayac=%0d expected 1 5 %0d",
               sonuc_gecerli, sonuc_cikis, sayac, exp_sayac);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    if (sonuc_gecerli !== 1'b0 || mesgul !== 1'b0) begin
      $display("[TB] FAIL single_done: got gecerli=%b mesgul=%b expected 0 0", sonuc_gecerli, mesgul);
      n_fail++;
    end
    n_checks++;
    calistir = 1'b0;
  endtask

  task automatic test_in_order;
    logic [3:0] expv [3] = '{4'b0010, 4'b0101, 4'b0000};
    bit ok;
    calistir = 1'b0;
    res_q.delete();
    cyc_q.delete();
    push_word(9'b001_101_011);
    push_word(9'b011_100_001);
    push_word(9'b110_000_111);
    calistir = 1'b1;
    wait_results(3, 30, ok);
    @(negedge clk);
    if (!ok) begin
      $display("[TB] FAIL order_timeout: got %0d results expected 3", res_q.size());
      n_fail++;
    end
    n_checks++;
    for (int i = 0; i < 3; i++) begin
      if (res_q[i] !== expv[i]) begin
        $display("[TB] FAIL order_result%0d: got %h expected %h", i, res_q[i], expv[i]);
        n_fail++;
      end
      n_checks++;
    end
    for (int i = 1; i < 3; i++) begin
      if (cyc_q[i] - cyc_q[i-1] != 2) begin
        $display("[TB] FAIL order_spacing%0d: got %0d expected 2", i, cyc_q[i] - cyc_q[i-1]);
        n_fail++;
      end
      n_checks++;
    end
    exp_sayac += 3;
    if (sayac !== 8'(exp_sayac) || bos !== 1'b1 || mesgul !== 1'b0) begin
      $display("[TB] FAIL order_final: got sayac=%0d bos=%b mesgul=%b expected %0d 1 0", sayac, bos, mesgul, exp_sayac);
      n_fail++;
    end
    n_checks++;
    calistir = 1'b0;
  endtask

  task automatic test_full;
    bit ok;
    calistir = 1'b0;
    res_q.delete();
    cyc_q.delete();
    for (int i = 0; i < 9; i++) begin
      push_word({3'b000, 3'(i), 3'd1});
      if (i == 6 && dolu !== 1'b0) begin
        $display("[TB] FAIL full_early: got dolu=%b expected 0", dolu);
        n_fail++;
      end
      if (i == 7 && (dolu !== 1'b1 || tasma !== 1'b0)) begin
        $display("[TB] FAIL full_eighth: got dolu=%b tasma=%b expected 1 0", dolu, tasma);
        n_fail++;
      end
      if (i == 8 && (tasma !== 1'b1 || dolu !== 1'b1)) begin
        $display("[TB] FAIL full_overflow: got tasma=%b dolu=%b expected 1 1", tasma, dolu);
        n_fail++;
      end
      if (i >= 6) n_checks++;
    end
    calistir = 1'b1;
    wait_results(8, 40, ok);
    repeat (4) @(negedge clk);
    if (!ok || res_q.size() != 8) begin
      $display("[TB] FAIL full_count: got %0d results expected 8", res_q.size());
      n_fail++;
    end
    n_checks++;
    for (int i = 0; i < 8; i++) begin
      if (res_q[i] !== 4'(i + 1)) begin
        $display("[TB] FAIL full_result%0d: got %h expected %h", i, res_q[i], 4'(i + 1));
        n_fail++;
      end
      n_checks++;
    end
    exp_sayac += 8;
    if (bos !== 1'b1 || sayac !== 8'(exp_sayac)) begin
      $display("[TB] FAIL full_drained: got bos=%b sayac=%0d expected 1 %0d", bos, sayac, exp_sayac);
      n_fail++;
    end
    n_checks++;
    calistir = 1'b0;
  endtask

  task automatic test_push_pop;
    bit   ok;
    bit   pop_next;
    int   pushes;
    int   nxt;
    calistir = 1'b0;
    res_q.delete();
    cyc_q.delete();
    for (int k = 0; k < 3; k++) push_word(mk(k));
    pushes = 0;
    nxt = 3;
    calistir = 1'b1;
    for (int c = 0; c < 80 && pushes < 10; c++) begin
      pop_next = calistir && !bos && (!mesgul || (!ifc.basla && ifc.bitti));
      if (pop_next) begin
        yaz = 1'b1;
        yaz_buyruk = mk(nxt);
        nxt++;
        pushes++;
      end else begin
        yaz = 1'b0;
      end
      @(negedge clk);
      if (pop_next) begin
        if (dut.count !== 4'd3) begin
          $display("[TB] FAIL pushpop_count: got %0d expected 3", dut.count);
          n_fail++;
        end
        n_checks++;
      end
    end
    yaz = 1'b0;
    wait_results(13, 60, ok);
    repeat (3) @(negedge clk);
    if (!ok || res_q.size() != 13) begin
      $display("[TB] FAIL pushpop_total: got %0d results expected 13", res_q.size());
      n_fail++;
    end
    n_checks++;
    for (int k = 0; k < 13; k++) begin
      if (res_q[k] !== 4'(k)) begin
        $display("[TB] FAIL pushpop_result%0d: got %h expected %h", k, res_q[k], 4'(k));
        n_fail++;
      end
      n_checks++;
    end
    exp_sayac += 13;
    if (bos !== 1'b1 || sayac !== 8'(exp_sayac) || tasma !== 1'b1) begin
      $display("[TB] FAIL pushpop_final: got bos=%b sayac=%0d tasma=%b expected 1 %0d 1", bos, sayac, tasma, exp_sayac);
      n_fail++;
    end
    n_checks++;
    calistir = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    stall = 1'b1;
    res_q.delete();
    cyc_q.delete();
    calistir = 1'b1;
    push_word(9'b000_001_001);
    n = 0;
    while (ifc.basla !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (ifc.basla !== 1'b1) begin
      $display("[TB] FAIL timeout_issue: got basla=%b expected 1", ifc.basla);
      n_fail++;
    end
    n_checks++;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (mesgul !== 1'b1 || hata !== 1'b0) begin
        $display("[TB] FAIL timeout_wait%0d: got mesgul=%b hata=%b expected 1 0", j, mesgul, hata);
        n_fail++;
      end
      n_checks++;
    end
    @(negedge clk);
    if (hata !== 1'b1 || mesgul !== 1'b0) begin
      $display("[TB] FAIL timeout_hata: got hata=%b mesgul=%b expected 1 0", hata, mesgul);
      n_fail++;
    end
    n_checks++;
    repeat (3) @(negedge clk);
    if (res_q.size() != 0 || sayac !== 8'(exp_sayac) || hata !== 1'b1) begin
      $display("[TB] FAIL timeout_nocapture: got results=%0d sayac=%0d hata=%b expected 0 %0d 1",
               res_q.size(), sayac, hata, exp_sayac);
      n_fail++;
    end
    n_checks++;
    calistir = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [27:0] obs;
    int n;
    stall = 1'b1;
    calistir = 1'b0;
    push_word(9'b000_010_010);
    push_word(9'b000_011_011);
    calistir = 1'b1;
    n = 0;
    while (ifc.basla !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (mesgul !== 1'b1 || ifc.basla !== 1'b0) begin
      $display("[TB] FAIL midreset_inwait: got mesgul=%b basla=%b expected 1 0", mesgul, ifc.basla);
      n_fail++;
    end
    n_checks++;
    res_q.delete();
    #2 rst = 1'b1;
    #1;
    obs = {ifc.basla, ifc.buyruk, sonuc_cikis, sonuc_gecerli, sayac, tasma, hata, mesgul, dolu, bos};
    if (obs !== 28'd1) begin
      $display("[TB] FAIL midreset_outputs: got %h expected %h", obs, 28'd1);
      n_fail++;
    end
    n_checks++;
    calistir = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    repeat (4) @(negedge clk);
    if (res_q.size() != 0 || sayac !== 8'd0 || mesgul !== 1'b0 || bos !== 1'b1) begin
      $display("[TB] FAIL midreset_after: got results=%0d sayac=%0d mesgul=%b bos=%b expected 0 0 0 1",
               res_q.size(), sayac, mesgul, bos);
      n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_in_order();
    test_full();
    test_push_pop();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected completion before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
